ne_frame_scheduler: RTL and testbench
=====================================

# ne_frame_scheduler

Ping-pong frame scheduler for the LDPC decoder core. It owns two Lmem code-symbol banks and allocates one to the input interface for loading. It launches the address-generator FSM on a full bank, then sequences the row-by-row unload of the decoded bank to the output interface. Loading of the next frame therefore overlaps decoding of the current one. The block sits between the input load/unload interface, the address-generator FSM (start/unload_start) and the output interface.

## Interface
- ROWDEPTH, 20, rows per frame per bank (Z/P rounded up)
- ROWWIDTH, 5, row address width
- TIMEOUT, 2048, decode watchdog limit in cycles (must exceed MAXITRS*2*(ROWDEPTH+PIPESTAGES))
- TOWIDTH, 12, watchdog counter width

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- load_req  in  1  input interface has a frame to write
- load_grant  out  1  one-cycle pulse: bank allocated to loader
- load_wr  in  1  one row written this cycle
- load_bank  out  1  bank being loaded
- load_addr  out  ROWWIDTH  row address for current load write
- dec_start  out  1  one-cycle pulse to address-generator start
- dec_bank  out  1  bank under decode; stable while decoding
- dec_busy  out  1  a bank is DECODING
- unload_start  in  1  one-cycle pulse from address generator: decode finished
- unload_valid  out  1  unload row presented
- unload_rdy  in  1  output interface accepts row
- unload_bank  out  1  bank being unloaded
- unload_addr  out  ROWWIDTH  row address being unloaded
- dec_abort  out  1  one-cycle pulse; drives address-generator loaden (watchdog)
- timeout_err  out  1  one-cycle pulse on watchdog expiry

## Operation
- Per-bank state: EMPTY, LOADING, FULL, DECODING, UNLOADING. At most one bank LOADING, one DECODING and one UNLOADING at a time.
- Load allocation: if load_req=1, no bank is LOADING and a bank is EMPTY, the lowest-index EMPTY bank is chosen. The bank becomes LOADING and load_grant pulses. load_req is ignored while a bank is LOADING.
- Load rows: load_addr = load row counter. Each load_wr increments it. The ROWDEPTH-th load_wr sets the bank to FULL and the counter to 0. load_wr with no LOADING bank is ignored.
- Decode launch: if no bank is DECODING and a FULL bank exists, take bank = next_dec pointer (frames decode in fill order). The pointer is valid only if that bank is FULL. The bank becomes DECODING, dec_start pulses, dec_bank is set, and next_dec toggles.
- Decode end: unload_start with a DECODING bank moves that bank to UNLOADING. unload_start with no DECODING bank is ignored.
- Unload: unload_valid=1 while a bank is UNLOADING, with unload_addr = unload counter. Each unload_valid&unload_rdy increments the counter. The transfer at address ROWDEPTH-1 sets the bank to EMPTY and the counter to 0.
- Simultaneous events on different banks apply independently in the same edge. Decisions use registered bank state, so a bank freed or filled at edge N is eligible at edge N+1.
- Reset (including mid-operation): both banks EMPTY, all counters 0, next_dec=0, all outputs 0. Any in-flight frame is discarded.

## Timing
- load_grant: asserted the cycle after the first sampled load_req meeting allocation conditions.
- load_bank and load_addr are registered. The first load_wr may occur in the cycle load_grant is high.
- dec_start: asserted the cycle after a FULL bank with no DECODING bank is first seen. The bank becomes FULL at edge N; dec_start is high in cycle N+1.
- unload_valid: asserted the cycle after unload_start is sampled.
- The next FULL bank's dec_start is one cycle after that, concurrent with unloading.
- unload_addr holds while unload_rdy=0.
- Minimum unload duration is ROWDEPTH cycles.

## Configuration
- NE_SCHED_TIMEOUT_EN defined:
  - A watchdog counter clears on dec_start and increments while a bank is DECODING.
  - On reaching TIMEOUT-1 without unload_start, the DECODING bank is set to EMPTY (frame dropped), and dec_abort and timeout_err pulse for one cycle.
  - unload_start in the expiry cycle takes priority, and no error is raised.
- NE_SCHED_TIMEOUT_EN undefined: no counter, and dec_abort and timeout_err are tied 0. The ports remain.

## Structure
- Package ne_sched_pkg: bank-state enum (3-bit), NUM_BANKS=2, default ROWDEPTH/ROWWIDTH/TIMEOUT.
- Sub-module ne_row_counter (enable, wrap at ROWDEPTH-1, last-flag output), instantiated twice: load counter and unload counter.

## Test plan
- Single frame: rst, load_req, 20 load_wr -> load_grant with load_bank=0, load_addr 0..19, dec_start one cycle after bank0 FULL, dec_bank=0. Then unload_start -> unload_valid next cycle, addr 0..19 with unload_rdy=1, bank0 EMPTY.
- Ping-pong: second frame loaded during decode -> grant bank1; unload_start for bank0 -> dec_start with dec_bank=1 exactly one cycle later, while bank0 unloads.
- Both banks busy: third load_req held -> no load_grant until bank0's 20th unload transfer; grant the cycle after, with load_bank=0.
- Backpressure: unload_rdy=0 for 5 cycles at addr 7 -> unload_addr holds 7, unload_valid stays 1, then completes at 19.
- Watchdog (macro on, TIMEOUT=64): no unload_start -> dec_abort and timeout_err pulse 64 cycles after dec_start, bank EMPTY; a later unload_start is ignored.
- rst asserted mid-unload at addr 10 -> next cycle all outputs 0, both banks EMPTY; a new load_req is granted bank0.

Source files
------------

// File: rtl/ne_sched_pkg.sv
// ne_sched_pkg: shared types and defaults for the ping-pong frame scheduler.
// Holds the per-bank state encoding, the bank count and default frame geometry.
package ne_sched_pkg;

    typedef enum logic [2:0] {
        BANK_EMPTY     = 3'd0,
        BANK_LOADING   = 3'd1,
        BANK_FULL      = 3'd2,
        BANK_DECODING  = 3'd3,
        BANK_UNLOADING = 3'd4
    } bank_state_t;

    localparam int NUM_BANKS    = 2;
    localparam int DEF_ROWDEPTH = 20;
    localparam int DEF_ROWWIDTH = 5;
    localparam int DEF_TIMEOUT  = 2048;
    localparam int DEF_TOWIDTH  = 12;

endpackage

// File: rtl/ne_frame_scheduler_if.sv
// ne_frame_scheduler_if: load, decode-control and unload signals of the scheduler.
// master = scheduler side, slave = loader / address generator / output side.
interface ne_frame_scheduler_if
    import ne_sched_pkg::*;
#(
    parameter int ROWWIDTH = DEF_ROWWIDTH
) ();

    logic                load_req;
    logic                load_grant;
    logic                load_wr;
    logic                load_bank;
    logic [ROWWIDTH-1:0] load_addr;
    logic                dec_start;
    logic                dec_bank;
    logic                dec_busy;
    logic                unload_start;
    logic                unload_valid;
    logic                unload_rdy;
    logic                unload_bank;
    logic [ROWWIDTH-1:0] unload_addr;
    logic                dec_abort;
    logic                timeout_err;

    modport master (
        input  load_req, load_wr, unload_start, unload_rdy,
        output load_grant, load_bank, load_addr, dec_start, dec_bank, dec_busy,
               unload_valid, unload_bank, unload_addr, dec_abort, timeout_err
    );

    modport slave (
        output load_req, load_wr, unload_start, unload_rdy,
        input  load_grant, load_bank, load_addr, dec_start, dec_bank, dec_busy,
               unload_valid, unload_bank, unload_addr, dec_abort, timeout_err
    );

endinterface

// File: rtl/ne_row_counter.sv
// ne_row_counter: row address counter that advances on enable and wraps to 0
// after ROWDEPTH-1; 'last' flags the final row so the caller can close a frame.
module ne_row_counter
    import ne_sched_pkg::*;
#(
    parameter int ROWDEPTH = DEF_ROWDEPTH,
    parameter int ROWWIDTH = DEF_ROWWIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic [ROWWIDTH-1:0] count,
    output logic                last
);

    assign last = (count == ROWWIDTH'(ROWDEPTH - 1));

    // Advance one row per enabled cycle, wrapping to 0 after the final row.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/ne_frame_scheduler.sv
// ne_frame_scheduler: ping-pong Lmem bank scheduler for the LDPC decoder core.
// Allocates a bank to the loader, launches decode on full banks in fill order
// and sequences row-by-row unload of decoded banks.
// Optional decode watchdog: define NE_SCHED_TIMEOUT_EN.
module ne_frame_scheduler
    import ne_sched_pkg::*;
#(
    parameter int ROWDEPTH = DEF_ROWDEPTH,
    parameter int ROWWIDTH = DEF_ROWWIDTH,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int TOWIDTH  = DEF_TOWIDTH
) (
    input logic                   clk,
    input logic                   rst,
    ne_frame_scheduler_if.master  bus
);

    bank_state_t bank_state [NUM_BANKS];
    bank_state_t bank_next  [NUM_BANKS];
    logic        next_dec;
    logic        next_dec_n;

    logic empty_any, empty_idx;
    logic loading_any, loading_idx;
    logic decoding_any, decoding_idx;
    logic unloading_any, unloading_idx;

    logic alloc, load_step, load_last, load_done, launch;
    logic dec_finish, unload_go, unload_step, unload_last, unload_done, expire;
    logic done_pend;

    logic load_grant_q, load_bank_q, dec_start_q, dec_bank_q, unload_bank_q;
    logic [ROWWIDTH-1:0] load_addr_w, unload_addr_w;

    if (TIMEOUT > (1 << TOWIDTH)) begin : g_timeout_width_check
        $error("TIMEOUT-1 does not fit in TOWIDTH bits");
    end

    // Summarise registered bank states; the lowest-index EMPTY bank wins.
    always_comb begin
        empty_any     = 1'b0;
        empty_idx     = 1'b0;
        loading_any   = 1'b0;
        loading_idx   = 1'b0;
        decoding_any  = 1'b0;
        decoding_idx  = 1'b0;
        unloading_any = 1'b0;
        unloading_idx = 1'b0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            case (bank_state[i])
                BANK_EMPTY:     begin empty_any     = 1'b1; empty_idx     = 1'(i); end
                BANK_LOADING:   begin loading_any   = 1'b1; loading_idx   = 1'(i); end
                BANK_DECODING:  begin decoding_any  = 1'b1; decoding_idx  = 1'(i); end
                BANK_UNLOADING: begin unloading_any = 1'b1; unloading_idx = 1'(i); end
                default: ;
            endcase
        end
    end

    assign alloc       = bus.load_req && !loading_any && empty_any;
    assign load_step   = bus.load_wr && loading_any;
    assign load_done   = load_step && load_last;
    assign launch      = !decoding_any && (bank_state[next_dec] == BANK_FULL);
    assign unload_step = unloading_any && bus.unload_rdy;
    assign unload_done = unload_step && unload_last;

    // A finished decode waits in DECODING (done_pend) if the unloader is still
    // busy with the other bank, so only one bank is ever UNLOADING.
    assign dec_finish  = decoding_any && (bus.unload_start || done_pend);
    assign unload_go   = dec_finish && (!unloading_any || unload_done);

`ifdef NE_SCHED_TIMEOUT_EN
    logic [TOWIDTH-1:0] wd_cnt;
    logic               abort_q;

    assign expire = decoding_any && !done_pend && !bus.unload_start &&
                    (wd_cnt == TOWIDTH'(TIMEOUT - 1));

    // Watchdog: restart at launch, count decode cycles, pulse abort on expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= '0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= expire;
            if (launch) begin
                wd_cnt <= '0;
            end else if (decoding_any && !expire) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    assign bus.dec_abort   = abort_q;
    assign bus.timeout_err = abort_q;
`else
    assign expire          = 1'b0;
    assign bus.dec_abort   = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // Next bank states; events touch different banks so they apply independently.
    // The decode pointer resyncs to a bank that fills while the other bank is not
    // FULL, so a lone frame always launches even after banks were reused unevenly.
    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_next[i] = bank_state[i];
        end
        next_dec_n = next_dec;
        if (alloc) begin
            bank_next[empty_idx] = BANK_LOADING;
        end
        if (load_done) begin
            bank_next[loading_idx] = BANK_FULL;
            if (bank_state[~loading_idx] != BANK_FULL) begin
                next_dec_n = loading_idx;
            end
        end
        if (launch) begin
            bank_next[next_dec] = BANK_DECODING;
            next_dec_n          = ~next_dec;
        end
        if (unload_go) begin
            bank_next[decoding_idx] = BANK_UNLOADING;
        end
        if (expire) begin
            bank_next[decoding_idx] = BANK_EMPTY;
        end
        if (unload_done) begin
            bank_next[unloading_idx] = BANK_EMPTY;
        end
    end

    // Bank state and decode-order pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_state[i] <= BANK_EMPTY;
            end
            next_dec <= 1'b0;
        end else begin
            bank_state <= bank_next;
            next_dec   <= next_dec_n;
        end
    end

    // Registered handshake pulses and bank selects presented to the interface.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_grant_q  <= 1'b0;
            load_bank_q   <= 1'b0;
            dec_start_q   <= 1'b0;
            dec_bank_q    <= 1'b0;
            unload_bank_q <= 1'b0;
            done_pend     <= 1'b0;
        end else begin
            load_grant_q <= alloc;
            dec_start_q  <= launch;
            done_pend    <= dec_finish && !unload_go;
            if (alloc) begin
                load_bank_q <= empty_idx;
            end
            if (launch) begin
                dec_bank_q <= next_dec;
            end
            if (unload_go) begin
                unload_bank_q <= decoding_idx;
            end
        end
    end

    ne_row_counter #(.ROWDEPTH(ROWDEPTH), .ROWWIDTH(ROWWIDTH)) u_load_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (load_step),
        .count (load_addr_w),
        .last  (load_last)
    );

    ne_row_counter #(.ROWDEPTH(ROWDEPTH), .ROWWIDTH(ROWWIDTH)) u_unload_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (unload_step),
        .count (unload_addr_w),
        .last  (unload_last)
    );

    assign bus.load_grant   = load_grant_q;
    assign bus.load_bank    = load_bank_q;
    assign bus.load_addr    = load_addr_w;
    assign bus.dec_start    = dec_start_q;
    assign bus.dec_bank     = dec_bank_q;
    assign bus.dec_busy     = decoding_any;
    assign bus.unload_valid = unloading_any;
    assign bus.unload_bank  = unload_bank_q;
    assign bus.unload_addr  = unload_addr_w;

endmodule

// File: tb/tb_ne_frame_scheduler.sv
// tb_ne_frame_scheduler: directed scenarios plus randomized traffic checked
// against a queue-based frame model. Watchdog scenario needs NE_SCHED_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_ne_frame_scheduler;

    localparam int RD = 20;
    localparam int RW = 5;
`ifdef NE_SCHED_TIMEOUT_EN
    localparam int TO = 64;
`else
    localparam int TO = 2048;
`endif
    localparam int S_EMPTY = 0, S_LOAD = 1, S_FULL = 2, S_DEC = 3, S_UNL = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ne_frame_scheduler_if #(.ROWWIDTH(RW)) bus ();

    ne_frame_scheduler #(.ROWDEPTH(RD), .ROWWIDTH(RW), .TIMEOUT(TO), .TOWIDTH(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: bank roles, a fill-order queue of FULL banks, row counts.
    int m_st [2];
    int m_q [$];
    int m_lcnt, m_ucnt, m_wd;
    bit m_grant, m_lbank, m_dstart, m_dbank, m_ubank, m_abort;

    task automatic model_step();
        int ld, dc, ul, b;
        int nst [2];
        if (rst) begin
            m_st = '{S_EMPTY, S_EMPTY};
            m_q.delete();
            m_lcnt = 0; m_ucnt = 0; m_wd = 0;
            m_grant = 0; m_lbank = 0; m_dstart = 0; m_dbank = 0; m_ubank = 0; m_abort = 0;
            return;
        end
        ld = -1; dc = -1; ul = -1;
        for (int i = 0; i < 2; i++) begin
            if (m_st[i] == S_LOAD) ld = i;
            if (m_st[i] == S_DEC)  dc = i;
            if (m_st[i] == S_UNL)  ul = i;
        end
        nst = m_st;
        m_grant = 0; m_dstart = 0; m_abort = 0;
        if (bus.load_req && ld < 0 && (m_st[0] == S_EMPTY || m_st[1] == S_EMPTY)) begin
            b = (m_st[0] == S_EMPTY) ? 0 : 1;
            nst[b] = S_LOAD; m_lbank = (b == 1); m_grant = 1;
        end
        if (dc < 0 && m_q.size() > 0) begin
            b = m_q.pop_front();
            nst[b] = S_DEC; m_dbank = (b == 1); m_dstart = 1; m_wd = 0;
        end
        if (bus.load_wr && ld >= 0) begin
            if (m_lcnt == RD - 1) begin
                nst[ld] = S_FULL; m_lcnt = 0; m_q.push_back(ld);
            end else m_lcnt++;
        end
        if (dc >= 0) begin
            if (bus.unload_start) begin
                nst[dc] = S_UNL; m_ubank = (dc == 1);
            end
`ifdef NE_SCHED_TIMEOUT_EN
            else if (m_wd == TO - 1) begin
                nst[dc] = S_EMPTY; m_abort = 1;
            end
`endif
            else m_wd++;
        end
        if (ul >= 0 && bus.unload_rdy) begin
            if (m_ucnt == RD - 1) begin
                nst[ul] = S_EMPTY; m_ucnt = 0;
            end else m_ucnt++;
        end
        m_st = nst;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.load_req = 0; bus.load_wr = 0; bus.unload_start = 0; bus.unload_rdy = 0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic load_rows(input int n);
        bus.load_wr = 1'b1;
        repeat (n) step();
        bus.load_wr = 1'b0;
    endtask

    task automatic load_frame();
        bus.load_req = 1'b1; step(); bus.load_req = 1'b0;
        load_rows(RD);
    endtask

    task automatic test_reset();
        logic [18:0] v;
        do_reset();
        v = {bus.load_grant, bus.load_bank, bus.load_addr, bus.dec_start, bus.dec_bank, bus.dec_busy,
             bus.unload_valid, bus.unload_bank, bus.unload_addr, bus.dec_abort, bus.timeout_err};
        total++;
        if (v !== '0) begin bad++; $display("[TB] FAIL reset_outputs: got %h expected 0", v); end
    endtask

    task automatic test_single_frame();
        do_reset();
        bus.load_req = 1'b1; step(); bus.load_req = 1'b0;
        total++;
        if (bus.load_grant !== 1'b1 || bus.load_bank !== 1'b0) begin
            bad++; $display("[TB] FAIL sf_grant: grant=%b bank=%b expected 1/0", bus.load_grant, bus.load_bank);
        end
        bus.load_wr = 1'b1;
        for (int i = 0; i < RD; i++) begin
            total++;
            if (bus.load_addr !== RW'(i)) begin bad++; $display("[TB] FAIL sf_load_addr: got %0d expected %0d", bus.load_addr, i); end
            if (i == 1) begin
                total++;
                if (bus.load_grant !== 1'b0) begin bad++; $display("[TB] FAIL sf_grant_pulse: got %b expected 0", bus.load_grant); end
            end
            step();
        end
        bus.load_wr = 1'b0;
        total++;
        if (bus.dec_start !== 1'b0 || bus.load_addr !== '0) begin
            bad++; $display("[TB] FAIL sf_full_cycle: dec_start=%b load_addr=%0d expected 0/0", bus.dec_start, bus.load_addr);
        end
        step();
        total++;
        if (bus.dec_start !== 1'b1 || bus.dec_bank !== 1'b0 || bus.dec_busy !== 1'b1) begin
            bad++; $display("[TB] FAIL sf_dec_start: start=%b bank=%b busy=%b expected 1/0/1", bus.dec_start, bus.dec_bank, bus.dec_busy);
        end
        step();
        total++;
        if (bus.dec_start !== 1'b0) begin bad++; $display("[TB] FAIL sf_dec_pulse: got %b expected 0", bus.dec_start); end
        bus.unload_start = 1'b1; step(); bus.unload_start = 1'b0;
        total++;
        if (bus.unload_valid !== 1'b1 || bus.unload_bank !== 1'b0 || bus.dec_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL sf_unload_begin: valid=%b bank=%b busy=%b expected 1/0/0", bus.unload_valid, bus.unload_bank, bus.dec_busy);
        end
        bus.unload_rdy = 1'b1;
        for (int i = 0; i < RD; i++) begin
            total++;
            if (bus.unload_addr !== RW'(i) || bus.unload_valid !== 1'b1) begin
                bad++; $display("[TB] FAIL sf_unload_addr: addr=%0d valid=%b expected %0d/1", bus.unload_addr, bus.unload_valid, i);
            end
            step();
        end
        bus.unload_rdy = 1'b0;
        total++;
        if (bus.unload_valid !== 1'b0) begin bad++; $display("[TB] FAIL sf_unload_end: valid=%b expected 0", bus.unload_valid); end
    endtask

    task automatic test_ping_pong();
        do_reset();
        load_frame(); step();
        bus.load_req = 1'b1; step(); bus.load_req = 1'b0;
        total++;
        if (bus.load_grant !== 1'b1 || bus.load_bank !== 1'b1) begin
            bad++; $display("[TB] FAIL pp_grant1: grant=%b bank=%b expected 1/1", bus.load_grant, bus.load_bank);
        end
        load_rows(RD); step(); step();
        total++;
        if (bus.dec_start !== 1'b0 || bus.dec_bank !== 1'b0 || bus.dec_busy !== 1'b1) begin
            bad++; $display("[TB] FAIL pp_wait: start=%b bank=%b busy=%b expected 0/0/1", bus.dec_start, bus.dec_bank, bus.dec_busy);
        end
        bus.unload_start = 1'b1; step(); bus.unload_start = 1'b0;
        total++;
        if (bus.unload_valid !== 1'b1 || bus.unload_bank !== 1'b0 || bus.dec_start !== 1'b0) begin
            bad++; $display("[TB] FAIL pp_unload0: valid=%b bank=%b start=%b expected 1/0/0", bus.unload_valid, bus.unload_bank, bus.dec_start);
        end
        bus.unload_rdy = 1'b1; step();
        total++;
        if (bus.dec_start !== 1'b1 || bus.dec_bank !== 1'b1 || bus.unload_addr !== RW'(1)) begin
            bad++; $display("[TB] FAIL pp_launch1: start=%b bank=%b uaddr=%0d expected 1/1/1", bus.dec_start, bus.dec_bank, bus.unload_addr);
        end
        repeat (RD - 1) step();
        bus.unload_rdy = 1'b0;
        total++;
        if (bus.unload_valid !== 1'b0 || bus.dec_busy !== 1'b1) begin
            bad++; $display("[TB] FAIL pp_end: valid=%b busy=%b expected 0/1", bus.unload_valid, bus.dec_busy);
        end
    endtask

    task automatic test_both_busy();
        int grants;
        do_reset();
        load_frame(); step();
        bus.load_req = 1'b1; step(); bus.load_req = 1'b0;
        load_rows(RD);
        bus.load_req = 1'b1;
        grants = 0;
        repeat (10) begin step(); if (bus.load_grant === 1'b1) grants++; end
        bus.unload_start = 1'b1; step(); bus.unload_start = 1'b0;
        bus.unload_rdy = 1'b1;
        for (int i = 0; i < RD; i++) begin
            if (bus.load_grant === 1'b1) grants++;
            step();
        end
        bus.unload_rdy = 1'b0;
        if (bus.load_grant === 1'b1) grants++;
        total++;
        if (grants != 0) begin bad++; $display("[TB] FAIL bb_no_grant: got %0d grants expected 0", grants); end
        step();
        bus.load_req = 1'b0;
        total++;
        if (bus.load_grant !== 1'b1 || bus.load_bank !== 1'b0) begin
            bad++; $display("[TB] FAIL bb_grant: grant=%b bank=%b expected 1/0", bus.load_grant, bus.load_bank);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        load_frame(); step();
        bus.unload_start = 1'b1; step(); bus.unload_start = 1'b0;
        bus.unload_rdy = 1'b1; repeat (7) step(); bus.unload_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (bus.unload_addr !== RW'(7) || bus.unload_valid !== 1'b1) begin
                bad++; $display("[TB] FAIL bp_hold: addr=%0d valid=%b expected 7/1", bus.unload_addr, bus.unload_valid);
            end
            step();
        end
        bus.unload_rdy = 1'b1;
        for (int i = 7; i < RD; i++) begin
            total++;
            if (bus.unload_addr !== RW'(i)) begin bad++; $display("[TB] FAIL bp_resume: addr=%0d expected %0d", bus.unload_addr, i); end
            step();
        end
        bus.unload_rdy = 1'b0;
        total++;
        if (bus.unload_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_done: valid=%b expected 0", bus.unload_valid); end
    endtask

`ifdef NE_SCHED_TIMEOUT_EN
    task automatic test_watchdog();
        int early;
        do_reset();
        load_frame(); step();
        early = 0;
        for (int k = 1; k <= TO; k++) begin
            step();
            if (k < TO && (bus.dec_abort !== 1'b0 || bus.timeout_err !== 1'b0)) early++;
        end
        total++;
        if (early != 0) begin bad++; $display("[TB] FAIL wd_early: got %0d early pulses expected 0", early); end
        total++;
        if (bus.dec_abort !== 1'b1 || bus.timeout_err !== 1'b1 || bus.dec_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL wd_expire: abort=%b err=%b busy=%b expected 1/1/0", bus.dec_abort, bus.timeout_err, bus.dec_busy);
        end
        step();
        total++;
        if (bus.dec_abort !== 1'b0 || bus.timeout_err !== 1'b0) begin
            bad++; $display("[TB] FAIL wd_pulse: abort=%b err=%b expected 0/0", bus.dec_abort, bus.timeout_err);
        end
        bus.unload_start = 1'b1; step(); bus.unload_start = 1'b0;
        total++;
        if (bus.unload_valid !== 1'b0) begin bad++; $display("[TB] FAIL wd_late_unload: valid=%b expected 0", bus.unload_valid); end
        load_frame(); step();
        total++;
        if (bus.dec_start !== 1'b1 || bus.dec_bank !== 1'b0) begin
            bad++; $display("[TB] FAIL wd_relaunch: start=%b bank=%b expected 1/0", bus.dec_start, bus.dec_bank);
        end
        repeat (TO - 1) step();
        bus.unload_start = 1'b1; step(); bus.unload_start = 1'b0;
        total++;
        if (bus.dec_abort !== 1'b0 || bus.timeout_err !== 1'b0 || bus.unload_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL wd_priority: abort=%b err=%b valid=%b expected 0/0/1", bus.dec_abort, bus.timeout_err, bus.unload_valid);
        end
    endtask
`else
    task automatic test_no_watchdog();
        int seen;
        do_reset();
        load_frame(); step();
        seen = 0;
        repeat (200) begin
            step();
            if (bus.dec_abort !== 1'b0 || bus.timeout_err !== 1'b0) seen++;
        end
        total++;
        if (seen != 0 || bus.dec_busy !== 1'b1) begin
            bad++; $display("[TB] FAIL nowd_idle: pulses=%0d busy=%b expected 0/1", seen, bus.dec_busy);
        end
        bus.unload_start = 1'b1; step(); bus.unload_start = 1'b0;
        total++;
        if (bus.unload_valid !== 1'b1) begin bad++; $display("[TB] FAIL nowd_unload: valid=%b expected 1", bus.unload_valid); end
    endtask
`endif

    task automatic test_reset_mid_unload();
        logic [18:0] v;
        do_reset();
        load_frame(); step();
        bus.load_req = 1'b1; step(); bus.load_req = 1'b0;
        load_rows(RD); step();
        bus.unload_start = 1'b1; step(); bus.unload_start = 1'b0;
        bus.unload_rdy = 1'b1; repeat (10) step();
        total++;
        if (bus.unload_addr !== RW'(10) || bus.dec_bank !== 1'b1) begin
            bad++; $display("[TB] FAIL rm_setup: uaddr=%0d dec_bank=%b expected 10/1", bus.unload_addr, bus.dec_bank);
        end
        rst = 1'b1; step(); rst = 1'b0; bus.unload_rdy = 1'b0;
        v = {bus.load_grant, bus.load_bank, bus.load_addr, bus.dec_start, bus.dec_bank, bus.dec_busy,
             bus.unload_valid, bus.unload_bank, bus.unload_addr, bus.dec_abort, bus.timeout_err};
        total++;
        if (v !== '0) begin bad++; $display("[TB] FAIL rm_outputs: got %h expected 0", v); end
        bus.load_req = 1'b1; step(); bus.load_req = 1'b0;
        total++;
        if (bus.load_grant !== 1'b1 || bus.load_bank !== 1'b0 || bus.load_addr !== '0) begin
            bad++; $display("[TB] FAIL rm_grant: grant=%b bank=%b addr=%0d expected 1/0/0", bus.load_grant, bus.load_bank, bus.load_addr);
        end
        repeat (3) step();
        total++;
        if (bus.dec_busy !== 1'b0 || bus.unload_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL rm_discard: busy=%b valid=%b expected 0/0", bus.dec_busy, bus.unload_valid);
        end
    endtask

    task automatic test_random();
        logic [18:0] exp_v, act_v;
        int fails;
        bit ul_any;
        do_reset();
        fails = 0;
        for (int c = 0; c < 3000 && fails < 10; c++) begin
            ul_any = (m_st[0] == S_UNL || m_st[1] == S_UNL);
            bus.load_req     = ($urandom_range(0, 2) == 0);
            bus.load_wr      = ($urandom_range(0, 1) == 1);
            bus.unload_rdy   = ($urandom_range(0, 2) != 0);
            bus.unload_start = !ul_any && ($urandom_range(0, 19) == 0);
            step();
            exp_v = {m_grant, m_lbank, RW'(m_lcnt), m_dstart, m_dbank,
                     (m_st[0] == S_DEC || m_st[1] == S_DEC), (m_st[0] == S_UNL || m_st[1] == S_UNL),
                     m_ubank, RW'(m_ucnt), m_abort, m_abort};
            act_v = {bus.load_grant, bus.load_bank, bus.load_addr, bus.dec_start, bus.dec_bank, bus.dec_busy,
                     bus.unload_valid, bus.unload_bank, bus.unload_addr, bus.dec_abort, bus.timeout_err};
            total++;
            if (act_v !== exp_v) begin
                bad++; fails++;
                $display("[TB] FAIL rand_cycle%0d: got %h expected %h", c, act_v, exp_v);
            end
        end
        bus.load_req = 0; bus.load_wr = 0; bus.unload_start = 0; bus.unload_rdy = 0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        rst = 1'b1;
        bus.load_req = 0; bus.load_wr = 0; bus.unload_start = 0; bus.unload_rdy = 0;
        test_reset();
        test_single_frame();
        test_ping_pong();
        test_both_busy();
        test_backpressure();
`ifdef NE_SCHED_TIMEOUT_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        test_reset_mid_unload();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
